// File: rtl/pc_unit.sv
// Fetch program-counter unit: holds the fetch PC and selects the next PC
// from sequential, branch, jump, jump-register, exception and ERET sources.
// A redirect that arrives while the front end is stalled is buffered and
// applied once the stall releases.
module pc_unit #(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     STEP       = 4,
    parameter int unsigned     ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [WIDTH-1:0] ADDR_LO    = 32'h0000_3000,
    parameter logic [WIDTH-1:0] ADDR_HI    = 32'h0000_6FFC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       npc_op,
    input  logic             br_cond,
    input  logic [WIDTH-1:0] br_base,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic [WIDTH-1:0] link_addr,
    output logic             redirect_pending,
    output logic             fetch_adel
);

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_op_e;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    npc_op_e          op;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    logic [WIDTH-1:0] base_seq;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic             redir;
    logic [WIDTH-1:0] redir_tgt;

    assign op       = npc_op_e'(npc_op);
    assign base_seq = br_base + STEP_W;
    assign imm_ext  = {{(WIDTH-16){imm16[15]}}, imm16};
    assign br_tgt   = base_seq + (imm_ext << ALIGN_BITS);
    assign j_tgt    = {base_seq[WIDTH-1:28], instr_index, 2'b00};

    // Decode the redirect request and its target from the D-stage operation.
    always_comb begin
        redir     = 1'b0;
        redir_tgt = br_tgt;
        unique case (op)
            NPC_SEQ: redir = 1'b0;
            NPC_BR:  begin redir = br_cond; redir_tgt = br_tgt;    end
            NPC_J:   begin redir = 1'b1;    redir_tgt = j_tgt;     end
            NPC_JR:  begin redir = 1'b1;    redir_tgt = jr_target; end
            default: redir = 1'b0;
        endcase
    end

    // Next-PC and pending-buffer selection in priority order.
    always_comb begin
        pc_d          = pc_q + STEP_W;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_req) begin
            pc_d         = EXC_VECTOR;
            pend_valid_d = 1'b0;
        end else if (eret) begin
            pc_d         = epc;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
            if (redir) begin
                pend_valid_d  = 1'b1;
                pend_target_d = redir_tgt;
            end
        end else if (redir) begin
            pc_d         = redir_tgt;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end
    end

    // PC and pending-redirect registers; reset overrides all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc               = pc_q;
    assign pc_plus_step     = pc_q + STEP_W;
    assign link_addr        = br_base + (STEP_W << 1);
    assign redirect_pending = pend_valid_q;
    assign fetch_adel       = ((pc_q & ALIGN_MASK) != '0) || (pc_q < ADDR_LO) || (pc_q > ADDR_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with hand-computed expected values.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_cond;
    logic [31:0] br_base;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic [31:0] link_addr;
    logic        redirect_pending;
    logic        fetch_adel;

    int tests_run;
    int tests_failed;

    pc_unit #(
        .WIDTH(32),
        .STEP(4),
        .ALIGN_BITS(2),
        .RESET_PC(32'h0000_3000),
        .EXC_VECTOR(32'h0000_4180),
        .ADDR_LO(32'h0000_3000),
        .ADDR_HI(32'h0000_6FFC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .npc_op(npc_op),
        .br_cond(br_cond),
        .br_base(br_base),
        .imm16(imm16),
        .instr_index(instr_index),
        .jr_target(jr_target),
        .exc_req(exc_req),
        .eret(eret),
        .epc(epc),
        .pc(pc),
        .pc_plus_step(pc_plus_step),
        .link_addr(link_addr),
        .redirect_pending(redirect_pending),
        .fetch_adel(fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b1; stall = 1'b0; npc_op = 2'b00; br_cond = 1'b0;
        br_base = '0; imm16 = '0; instr_index = '0; jr_target = '0;
        exc_req = 1'b0; eret = 1'b0; epc = '0;

        // Reset and free-running sequence
        step();
        check("reset_pc", pc, 32'h3000);
        check("reset_pend", {31'b0, redirect_pending}, 32'd0);
        check("reset_adel", {31'b0, fetch_adel}, 32'd0);
        check("reset_pps", pc_plus_step, 32'h3004);
        reset = 1'b0;
        step(); check("seq1", pc, 32'h3004);
        step(); check("seq2", pc, 32'h3008);
        step(); check("seq3", pc, 32'h300C);
        check("seq3_pps", pc_plus_step, 32'h3010);
        check("seq3_adel", {31'b0, fetch_adel}, 32'd0);

        // Taken and not-taken branch
        br_base = 32'h3010; imm16 = 16'hFFFC; npc_op = 2'b01; br_cond = 1'b1;
        #1 check("link_addr", link_addr, 32'h3018);
        step(); check("br_taken", pc, 32'h3004);
        br_cond = 1'b0;
        step(); check("br_not_taken", pc, 32'h3008);

        // Jump and jump-register
        br_base = 32'h3020; instr_index = 26'h0000D00; npc_op = 2'b10;
        step(); check("jump", pc, 32'h3400);
        jr_target = 32'h3456; npc_op = 2'b11;
        step(); check("jr", pc, 32'h3456);
        check("jr_adel", {31'b0, fetch_adel}, 32'd1);
        npc_op = 2'b00;
        step(); check("after_jr_seq", pc, 32'h345A);

        // Stall with buffered redirect
        stall = 1'b1; jr_target = 32'h3100; npc_op = 2'b11;
        step(); check("stall_hold0", pc, 32'h345A);
        check("stall_pend0", {31'b0, redirect_pending}, 32'd1);
        npc_op = 2'b00;
        step(); check("stall_hold1", pc, 32'h345A);
        step(); check("stall_hold2", pc, 32'h345A);
        check("stall_pend2", {31'b0, redirect_pending}, 32'd1);
        stall = 1'b0;
        step(); check("pend_apply", pc, 32'h3100);
        check("pend_cleared", {31'b0, redirect_pending}, 32'd0);
        step(); check("pend_after", pc, 32'h3104);

        // Newer redirect overwrites pending one
        stall = 1'b1; npc_op = 2'b11; jr_target = 32'h3200;
        step(); check("ovr_hold0", pc, 32'h3104);
        jr_target = 32'h3300;
        step(); check("ovr_hold1", pc, 32'h3104);
        stall = 1'b0; npc_op = 2'b00;
        step(); check("ovr_apply", pc, 32'h3300);

        // Live redirect beats pending
        stall = 1'b1; npc_op = 2'b11; jr_target = 32'h3400;
        step(); check("live_hold", pc, 32'h3300);
        stall = 1'b0; jr_target = 32'h3500;
        step(); check("live_wins", pc, 32'h3500);
        check("live_pend", {31'b0, redirect_pending}, 32'd0);

        // Exception during stall with pending redirect
        stall = 1'b1; jr_target = 32'h3600;
        step(); check("exc_pre_pend", {31'b0, redirect_pending}, 32'd1);
        exc_req = 1'b1; npc_op = 2'b00;
        step(); check("exc_pc", pc, 32'h4180);
        check("exc_pend", {31'b0, redirect_pending}, 32'd0);
        exc_req = 1'b0; stall = 1'b0;
        step(); check("exc_next", pc, 32'h4184);

        // ERET, then exc_req with eret together
        eret = 1'b1; epc = 32'h3008;
        step(); check("eret", pc, 32'h3008);
        eret = 1'b0;
        step(); check("eret_next", pc, 32'h300C);
        exc_req = 1'b1; eret = 1'b1;
        step(); check("exc_beats_eret", pc, 32'h4180);
        exc_req = 1'b0; eret = 1'b0;

        // Reset mid-stall with pending redirect
        stall = 1'b1; npc_op = 2'b11; jr_target = 32'h3700;
        step(); check("rst_pre_pend", {31'b0, redirect_pending}, 32'd1);
        reset = 1'b1;
        step(); check("rst_mid_pc", pc, 32'h3000);
        check("rst_mid_pend", {31'b0, redirect_pending}, 32'd0);
        reset = 1'b0; stall = 1'b0; npc_op = 2'b00;
        step(); check("rst_mid_next", pc, 32'h3004);

        // Upper address boundary
        npc_op = 2'b11; jr_target = 32'h6FF8;
        step(); check("bnd_6ff8", pc, 32'h6FF8);
        check("bnd_6ff8_adel", {31'b0, fetch_adel}, 32'd0);
        npc_op = 2'b00;
        step(); check("bnd_6ffc", pc, 32'h6FFC);
        check("bnd_6ffc_adel", {31'b0, fetch_adel}, 32'd0);
        step(); check("bnd_7000", pc, 32'h7000);
        check("bnd_7000_adel", {31'b0, fetch_adel}, 32'd1);

        // Wrap-around
        npc_op = 2'b11; jr_target = 32'hFFFF_FFFC;
        step(); check("wrap_top", pc, 32'hFFFF_FFFC);
        check("wrap_top_pps", pc_plus_step, 32'h0000_0000);
        check("wrap_top_adel", {31'b0, fetch_adel}, 32'd1);
        npc_op = 2'b00;
        step(); check("wrap_zero", pc, 32'h0000_0000);
        check("wrap_zero_adel", {31'b0, fetch_adel}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
